// File: rtl/fgcg_pkg.sv
// Shared definitions for the fine-grained clock-gated (FGCG) pipeline blocks.
package fgcg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAKE = 2'd1,
        RUN  = 2'd2
    } fgcg_state_e;

endpackage

// File: rtl/fgcg_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and an asynchronous head read.
module fgcg_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fgcg_issue_ctrl.sv
// Source-side issuer for a chain of clock-gated stages: raises the stage enable one
// cycle ahead of the data and holds it through short gaps.
module fgcg_issue_ctrl
    import fgcg_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    output logic                         clk_en_out,
    output logic                         valid_out,
    output logic [W-1:0]                 data_out,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         busy
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    fgcg_state_e   state_q, state_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          clk_en_q, clk_en_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  data_q, data_d;
    logic          fifo_full, fifo_empty, push, pop;
    logic [W-1:0]  fifo_head;

    assign push = in_valid && !fifo_full;

    fgcg_sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstb      (rstb),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        clk_en_d   = clk_en_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                clk_en_d = 1'b0;
                if (!fifo_empty) begin
                    state_d  = WAKE;
                    clk_en_d = 1'b1;
                end
            end
            WAKE: begin
                pop        = !fifo_empty;
                state_d    = RUN;
                clk_en_d   = 1'b1;
                idle_cnt_d = '0;
            end
            RUN: begin
                // Items arriving during hold-off go straight out; no second wake-up.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d    = IDLE;
                    clk_en_d   = 1'b0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                clk_en_d   = 1'b0;
                idle_cnt_d = '0;
            end
        endcase
        if (pop) begin
            valid_d = 1'b1;
            data_d  = fifo_head;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            clk_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            clk_en_q   <= clk_en_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    assign clk_en_out = clk_en_q;
    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign in_ready   = !fifo_full;
    assign busy       = (state_q != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_fgcg_issue_ctrl.sv
// Directed and randomized checks of fgcg_issue_ctrl against a queue-based behavioural model.
module tb_fgcg_issue_ctrl;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, clk_en_out, valid_out, busy;
    logic [W-1:0]  data_out;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    fgcg_issue_ctrl #(
        .W           (W),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .clk_en_out (clk_en_out),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model: items waiting, whether the stage chain is asleep / waking / awake,
    // and how many consecutive empty awake cycles have elapsed.
    logic [W-1:0] mq[$];
    logic [W-1:0] obs_q[$];
    int           m_phase;
    bit           m_en, m_valid;
    logic [W-1:0] m_data;
    int           m_gap;
    logic         p_en, p_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_en    = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_gap   = 0;
        p_en    = 1'b0;
        p_valid = 1'b0;
    endtask

    task automatic model_edge();
        bit do_push;
        do_push = in_valid && (mq.size() < DEPTH);
        m_valid = 1'b0;
        if (m_phase == 0) begin
            if (mq.size() != 0) begin
                m_phase = 1;
                m_en    = 1'b1;
            end
        end else if (m_phase == 1) begin
            m_data  = mq.pop_front();
            m_valid = 1'b1;
            m_phase = 2;
            m_gap   = 0;
        end else begin
            if (mq.size() != 0) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
                m_gap   = 0;
            end else begin
                m_gap++;
                if (m_gap == HOLD) begin
                    m_phase = 0;
                    m_en    = 1'b0;
                    m_gap   = 0;
                end
            end
        end
        if (do_push) mq.push_back(in_data);
    endtask

    task automatic check_all(input string where);
        chk({where, ".clk_en"},   clk_en_out, m_en);
        chk({where, ".valid"},    valid_out,  m_valid);
        chk({where, ".data"},     data_out,   m_data);
        chk({where, ".level"},    fifo_level, mq.size());
        chk({where, ".in_ready"}, in_ready,   mq.size() < DEPTH);
        chk({where, ".busy"},     busy,       (m_phase != 0) || (mq.size() != 0));
    endtask

    task automatic step(input string where, input bit v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(where);
        // Each valid cycle and the bubble after it need the enable one cycle earlier.
        if (valid_out === 1'b1 || (p_valid === 1'b1 && valid_out === 1'b0))
            chk({where, ".en_ahead"}, p_en, 1'b1);
        if (valid_out === 1'b1) obs_q.push_back(data_out);
        p_en     = clk_en_out;
        p_valid  = valid_out;
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input string where);
        in_valid = 1'b0;
        rstb     = 1'b0;
        #1;
        model_reset();
        check_all({where, ".async"});
        @(posedge clk);
        #1;
        check_all({where, ".held"});
        rstb = 1'b1;
    endtask

    initial begin
        // Test 1: reset, then idle.
        #2;
        model_reset();
        check_all("t1_rst");
        @(posedge clk);
        #1;
        rstb = 1'b1;
        repeat (10) step("t1_idle", 1'b0, '0);

        // Test 2: single item from idle.
        step("t2_push", 1'b1, 8'hA5);
        step("t2_e2", 1'b0, '0);
        chk("t2_wake_en", clk_en_out, 1'b1);
        chk("t2_wake_valid", valid_out, 1'b0);
        step("t2_e3", 1'b0, '0);
        chk("t2_valid", valid_out, 1'b1);
        chk("t2_data", data_out, 8'hA5);
        step("t2_e4", 1'b0, '0);
        chk("t2_bubble", valid_out, 1'b0);
        chk("t2_hold_en", clk_en_out, 1'b1);
        step("t2_e5", 1'b0, '0);
        chk("t2_sleep", clk_en_out, 1'b0);
        repeat (3) step("t2_idle", 1'b0, '0);

        // Test 3: six back-to-back pushes.
        obs_q.delete();
        begin
            int k;
            int guard;
            bit acc;
            k = 0;
            guard = 0;
            while (k < 6 && guard < 50) begin
                acc = (mq.size() < DEPTH);
                step("t3_push", 1'b1, W'(8'h10 + k));
                if (acc) k++;
                guard++;
            end
            chk("t3_pushed", k, 6);
        end
        repeat (8) step("t3_drain", 1'b0, '0);
        chk("t3_count", obs_q.size(), 6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++)
            chk("t3_order", obs_q[i], W'(8'h10 + i));

        // Test 4: item arriving during hold-off.
        step("t4_push1", 1'b1, 8'h01);
        step("t4_wake", 1'b0, '0);
        step("t4_v1", 1'b0, '0);
        chk("t4_v1_data", data_out, 8'h01);
        step("t4_push2", 1'b1, 8'h02);
        chk("t4_bubble", valid_out, 1'b0);
        chk("t4_en_kept", clk_en_out, 1'b1);
        step("t4_v2", 1'b0, '0);
        chk("t4_v2_valid", valid_out, 1'b1);
        chk("t4_v2_data", data_out, 8'h02);
        repeat (4) step("t4_idle", 1'b0, '0);

        // Test 5: push and pop on the same edge at level 1.
        step("t5_a", 1'b1, 8'h21);
        step("t5_b", 1'b1, 8'h22);
        step("t5_c", 1'b0, '0);
        chk("t5_lvl_before", fifo_level, 1);
        step("t5_same", 1'b1, 8'h23);
        chk("t5_lvl_same", fifo_level, 1);
        chk("t5_data22", data_out, 8'h22);
        step("t5_last", 1'b0, '0);
        chk("t5_data23", data_out, 8'h23);
        repeat (4) step("t5_idle", 1'b0, '0);

        // Test 6: reset mid-burst discards queued items.
        step("t6_a", 1'b1, 8'h31);
        step("t6_b", 1'b1, 8'h32);
        step("t6_c", 1'b1, 8'h33);
        obs_q.delete();
        do_reset("t6_rst");
        repeat (8) step("t6_after", 1'b0, '0);
        chk("t6_stale", obs_q.size(), 0);

        // Randomized traffic with varying density and occasional resets.
        for (int i = 0; i < 600; i++) begin
            int dens;
            dens = (i / 75) % 5;
            if ($urandom_range(0, 199) == 0)
                do_reset("rnd_rst");
            else
                step("rnd", ($urandom_range(0, 3) < dens), W'($urandom));
        end
        repeat (6) step("rnd_drain", 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
